// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - multicycle load/store sequencer with read-modify-write for sub-word stores.
// Optional misalignment trapping is enabled by defining MEMCTRL_ALIGN_CHECK_EN.
module mem_access_ctrl #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        ld_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic [31:0] load_data,
    output logic        ext_sel,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_CAP,
        S_MERGE,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [1:0] WAIT_INIT = 2'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);

    state_t      r_state;
    logic [2:0]  r_op;
    logic [1:0]  r_lane;
    logic [15:0] r_wdata;
    logic        r_uns;
    logic        r_bad;
    logic [1:0]  r_cnt;
    logic [31:0] r_rdata;
    logic [31:0] r_mem_addr;
    logic        r_mem_wr;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_load_data;
    logic        r_ext_sel;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic        w_misaligned;
    logic        w_bad;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;
    logic [31:0] w_mask;
    logic [31:0] w_ins;
    logic [31:0] w_merged;

`ifdef MEMCTRL_ALIGN_CHECK_EN
    assign w_misaligned = ((op[1:0] == 2'b01) && addr[0]) ||
                          ((op[1:0] == 2'b00) && (addr[1:0] != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif
    assign w_bad = (op[1:0] == 2'b11) || w_misaligned;

    // Lane selection and merge work on the captured word and the registered request only.
    always_comb begin
        w_byte = 8'(r_rdata >> {r_lane, 3'b000});
        w_half = 16'(r_rdata >> {r_lane[1], 4'b0000});
        case (r_op[1:0])
            2'b00:   w_load_ext = r_rdata;
            2'b01:   w_load_ext = r_uns ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load_ext = r_uns ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
        endcase
        if (r_op[1:0] == 2'b01) begin
            w_mask = 32'h0000_FFFF << {r_lane[1], 4'b0000};
            w_ins  = {2{r_wdata}};
        end else begin
            w_mask = 32'h0000_00FF << {r_lane, 3'b000};
            w_ins  = {4{r_wdata[7:0]}};
        end
        w_merged = (r_rdata & ~w_mask) | (w_ins & w_mask);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_op        <= 3'b000;
            r_lane      <= 2'b00;
            r_wdata     <= 16'h0000;
            r_uns       <= 1'b0;
            r_bad       <= 1'b0;
            r_cnt       <= 2'b00;
            r_rdata     <= 32'h0;
            r_mem_addr  <= 32'h0;
            r_mem_wr    <= 1'b0;
            r_mem_wdata <= 32'h0;
            r_load_data <= 32'h0;
            r_ext_sel   <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_mem_wr  <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_ext_sel <= 1'b1;
            // busy spans the done cycle; a start accepted in that cycle keeps it high
            if (r_done) begin
                r_busy <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_lane  <= addr[1:0];
                        r_wdata <= wdata[15:0];
                        r_uns   <= ld_unsigned;
                        r_bad   <= w_bad;
                        r_busy  <= 1'b1;
                        if (w_bad) begin
                            r_state <= S_DONE;
                        end else if (op == 3'b100) begin
                            r_mem_addr  <= {addr[31:2], 2'b00};
                            r_mem_wdata <= wdata;
                            r_state     <= S_WR;
                        end else begin
                            r_mem_addr <= {addr[31:2], 2'b00};
                            r_state    <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (MEM_LAT > 1) begin
                        r_cnt   <= WAIT_INIT;
                        r_state <= S_WAIT;
                    end else begin
                        r_state <= S_CAP;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 2'b00) begin
                        r_state <= S_CAP;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                S_CAP: begin
                    r_rdata <= mem_rdata;
                    r_state <= r_op[2] ? S_MERGE : S_DONE;
                end
                S_MERGE: begin
                    r_mem_wdata <= w_merged;
                    r_state     <= S_WR;
                end
                S_WR: begin
                    r_mem_wr <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_done <= 1'b1;
                    r_err  <= r_bad;
                    if (!r_op[2] && !r_bad) begin
                        r_load_data <= w_load_ext;
                        r_ext_sel   <= 1'b0;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wr    = r_mem_wr;
    assign mem_wdata = r_mem_wdata;
    assign load_data = r_load_data;
    assign ext_sel   = r_ext_sel;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized bench for mem_access_ctrl at MEM_LAT 1 and 3 against a transaction-level model.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic        ld_unsigned = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;

    logic [31:0] mem_rdata [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] load_data [2];
    logic        mem_wr    [2];
    logic        ext_sel   [2];
    logic        busy      [2];
    logic        done      [2];
    logic        err       [2];

    logic [31:0] mem    [2][16];
    logic [31:0] pipe   [2][4];
    logic [31:0] exp_ld [2];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.MEM_LAT(1)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .op(op), .ld_unsigned(ld_unsigned),
        .addr(addr), .wdata(wdata), .mem_rdata(mem_rdata[0]), .mem_addr(mem_addr[0]),
        .mem_wr(mem_wr[0]), .mem_wdata(mem_wdata[0]), .load_data(load_data[0]),
        .ext_sel(ext_sel[0]), .busy(busy[0]), .done(done[0]), .err(err[0])
    );

    mem_access_ctrl #(.MEM_LAT(3)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .op(op), .ld_unsigned(ld_unsigned),
        .addr(addr), .wdata(wdata), .mem_rdata(mem_rdata[1]), .mem_addr(mem_addr[1]),
        .mem_wr(mem_wr[1]), .mem_wdata(mem_wdata[1]), .load_data(load_data[1]),
        .ext_sel(ext_sel[1]), .busy(busy[1]), .done(done[1]), .err(err[1])
    );

    // Memory read data appears exactly MEM_LAT edges after the address is presented.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            pipe[g][0] <= mem[g][mem_addr[g][5:2]];
            for (int k = 1; k < 4; k++) pipe[g][k] <= pipe[g][k-1];
        end
    end
    assign mem_rdata[0] = pipe[0][0];
    assign mem_rdata[1] = pipe[1][2];

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    task automatic set_word(input int idx, input logic [31:0] val);
        mem[0][idx] = val;
        mem[1][idx] = val;
    endtask

    task automatic do_op(input logic [2:0] t_op, input logic t_uns, input logic [31:0] t_addr,
                         input logic [31:0] t_wdata, input bit hold,
                         output logic [31:0] obs_ld, output logic [31:0] obs_wd);
        logic        bad, ld, st, upd;
        logic [31:0] word, part, new_ld, exp_wd, mask, ins;
        int          sa;
        int          x [2];
        int          xmax;
        bad = (t_op[1:0] == 2'b11);
`ifdef MEMCTRL_ALIGN_CHECK_EN
        if ((t_op[1:0] == 2'b01 && t_addr[0]) || (t_op[1:0] == 2'b00 && t_addr[1:0] != 2'b00)) bad = 1'b1;
`endif
        ld = !bad && !t_op[2];
        st = !bad && t_op[2];
        word = mem[0][t_addr[5:2]];
        case (t_op[1:0])
            2'b00: begin
                new_ld = word; mask = 32'hFFFF_FFFF; ins = t_wdata;
            end
            2'b01: begin
                sa = 16 * int'(t_addr[1]);
                part = word >> sa;
                new_ld = t_uns ? {16'h0, part[15:0]} : {{16{part[15]}}, part[15:0]};
                mask = 32'h0000_FFFF << sa; ins = (t_wdata & 32'h0000_FFFF) << sa;
            end
            default: begin
                sa = 8 * int'(t_addr[1:0]);
                part = word >> sa;
                new_ld = t_uns ? {24'h0, part[7:0]} : {{24{part[7]}}, part[7:0]};
                mask = 32'h0000_00FF << sa; ins = (t_wdata & 32'h0000_00FF) << sa;
            end
        endcase
        exp_wd = (word & ~mask) | ins;
        for (int g = 0; g < 2; g++) begin
            if (bad) x[g] = 1;
            else if (ld) x[g] = lat_of(g) + 2;
            else if (t_op == 3'b100) x[g] = 2;
            else x[g] = lat_of(g) + 4;
        end
        xmax = (x[0] > x[1]) ? x[0] : x[1];
        obs_ld = exp_ld[0];
        obs_wd = 32'h0;

        @(negedge clk);
        start = 1'b1; op = t_op; ld_unsigned = t_uns; addr = t_addr; wdata = t_wdata;
        @(posedge clk);
        for (int cyc = 0; cyc <= xmax + 1; cyc++) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                n_vec++;
                if (done[g] !== (cyc == x[g])) begin
                    n_bad++; $display("FAIL done dut%0d op%0d cyc%0d: got %b want %b", g, t_op, cyc, done[g], cyc == x[g]);
                end
                n_vec++;
                if (err[g] !== (cyc == x[g] && bad)) begin
                    n_bad++; $display("FAIL err dut%0d op%0d cyc%0d: got %b want %b", g, t_op, cyc, err[g], cyc == x[g] && bad);
                end
                n_vec++;
                if (ext_sel[g] !== !(cyc == x[g] && ld)) begin
                    n_bad++; $display("FAIL ext_sel dut%0d op%0d cyc%0d: got %b want %b", g, t_op, cyc, ext_sel[g], !(cyc == x[g] && ld));
                end
                n_vec++;
                if (busy[g] !== (cyc <= x[g])) begin
                    n_bad++; $display("FAIL busy dut%0d op%0d cyc%0d: got %b want %b", g, t_op, cyc, busy[g], cyc <= x[g]);
                end
                upd = ld && (cyc >= x[g]);
                n_vec++;
                if (load_data[g] !== (upd ? new_ld : exp_ld[g])) begin
                    n_bad++; $display("FAIL load_data dut%0d op%0d cyc%0d: got %h want %h", g, t_op, cyc, load_data[g], upd ? new_ld : exp_ld[g]);
                end
                n_vec++;
                if (mem_wr[g] !== (st && cyc == x[g] - 1)) begin
                    n_bad++; $display("FAIL mem_wr dut%0d op%0d cyc%0d: got %b want %b", g, t_op, cyc, mem_wr[g], st && cyc == x[g] - 1);
                end
                if (mem_wr[g] === 1'b1) begin
                    n_vec++;
                    if (mem_addr[g] !== {t_addr[31:2], 2'b00} || mem_wdata[g] !== exp_wd) begin
                        n_bad++; $display("FAIL write dut%0d op%0d: got %h@%h want %h@%h", g, t_op, mem_wdata[g], mem_addr[g], exp_wd, {t_addr[31:2], 2'b00});
                    end
                    mem[g][mem_addr[g][5:2]] = mem_wdata[g];
                    if (g == 0) obs_wd = mem_wdata[0];
                end
                if (cyc == x[g] && !bad) begin
                    n_vec++;
                    if (mem_addr[g] !== {t_addr[31:2], 2'b00}) begin
                        n_bad++; $display("FAIL mem_addr dut%0d op%0d: got %h want %h", g, t_op, mem_addr[g], {t_addr[31:2], 2'b00});
                    end
                end
                if (cyc == x[g] && g == 0) obs_ld = load_data[0];
            end
            start = hold && (cyc < x[0]);
            op = 3'($urandom); ld_unsigned = 1'($urandom); addr = $urandom; wdata = $urandom;
        end
        start = 1'b0;
        if (ld) begin
            exp_ld[0] = new_ld;
            exp_ld[1] = new_ld;
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 16; i++) set_word(i, 32'h0);
        exp_ld[0] = 32'h0;
        exp_ld[1] = 32'h0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            n_vec++;
            if (mem_addr[g] !== 32'h0 || mem_wr[g] !== 1'b0 || mem_wdata[g] !== 32'h0 || load_data[g] !== 32'h0 ||
                ext_sel[g] !== 1'b1 || busy[g] !== 1'b0 || done[g] !== 1'b0 || err[g] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_values dut%0d: got addr=%h wr=%b wd=%h ld=%h es=%b bz=%b dn=%b er=%b want 0,0,0,0,1,0,0,0",
                         g, mem_addr[g], mem_wr[g], mem_wdata[g], load_data[g], ext_sel[g], busy[g], done[g], err[g]);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_lw;
        logic [31:0] ld, wd;
        set_word(4, 32'hDEADBEEF);
        do_op(3'b000, 1'b0, 32'h10, 32'h0, 1'b0, ld, wd);
        n_vec++;
        if (ld !== 32'hDEADBEEF) begin
            n_bad++; $display("FAIL lw_0x10: got %h want DEADBEEF", ld);
        end
    endtask

    task automatic test_lb_ext;
        logic [31:0] ld, wd;
        set_word(4, 32'h80FF1234);
        do_op(3'b010, 1'b0, 32'h13, 32'h0, 1'b0, ld, wd);
        n_vec++;
        if (ld !== 32'hFFFFFF80) begin
            n_bad++; $display("FAIL lb_signed: got %h want FFFFFF80", ld);
        end
        do_op(3'b010, 1'b1, 32'h13, 32'h0, 1'b0, ld, wd);
        n_vec++;
        if (ld !== 32'h00000080) begin
            n_bad++; $display("FAIL lb_unsigned: got %h want 00000080", ld);
        end
        do_op(3'b001, 1'b0, 32'h12, 32'h0, 1'b0, ld, wd);
        n_vec++;
        if (ld !== 32'hFFFF80FF) begin
            n_bad++; $display("FAIL lh_signed: got %h want FFFF80FF", ld);
        end
    endtask

    task automatic test_sh_rmw;
        logic [31:0] ld, wd;
        set_word(8, 32'h11223344);
        do_op(3'b101, 1'b0, 32'h22, 32'h0000ABCD, 1'b0, ld, wd);
        n_vec++;
        if (wd !== 32'hABCD3344) begin
            n_bad++; $display("FAIL sh_rmw: got %h want ABCD3344", wd);
        end
    endtask

    task automatic test_misaligned;
        logic [31:0] ld, wd, prev;
        set_word(8, 32'h1122F344);
        prev = exp_ld[0];
        do_op(3'b001, 1'b0, 32'h21, 32'h0, 1'b0, ld, wd);
        n_vec++;
`ifdef MEMCTRL_ALIGN_CHECK_EN
        if (ld !== prev) begin
            n_bad++; $display("FAIL lh_misaligned: got %h want %h", ld, prev);
        end
`else
        if (ld !== 32'hFFFFF344 || ld === prev) begin
            n_bad++; $display("FAIL lh_misaligned: got %h want FFFFF344", ld);
        end
`endif
    endtask

    task automatic test_reset_during_sb;
        logic [31:0] ld, wd;
        set_word(2, 32'h5566_7788);
        @(negedge clk);
        start = 1'b1; op = 3'b110; ld_unsigned = 1'b0; addr = 32'h09; wdata = 32'h0000_00A5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        for (int g = 0; g < 2; g++) begin
            n_vec++;
            if (mem_wr[g] !== 1'b0 || busy[g] !== 1'b0 || done[g] !== 1'b0 || err[g] !== 1'b0 ||
                ext_sel[g] !== 1'b1 || load_data[g] !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_mid_sb dut%0d: got wr=%b bz=%b dn=%b er=%b es=%b ld=%h want 0,0,0,0,1,0",
                         g, mem_wr[g], busy[g], done[g], err[g], ext_sel[g], load_data[g]);
            end
        end
        exp_ld[0] = 32'h0;
        exp_ld[1] = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                n_vec++;
                if (mem_wr[g] !== 1'b0 || busy[g] !== 1'b0) begin
                    n_bad++; $display("FAIL after_reset dut%0d c%0d: got wr=%b bz=%b want 0,0", g, c, mem_wr[g], busy[g]);
                end
            end
        end
        n_vec++;
        if (mem[0][2] !== 32'h5566_7788 || mem[1][2] !== 32'h5566_7788) begin
            n_bad++; $display("FAIL sb_dropped: got %h/%h want 55667788", mem[0][2], mem[1][2]);
        end
        do_op(3'b000, 1'b0, 32'h08, 32'h0, 1'b0, ld, wd);
        n_vec++;
        if (ld !== 32'h5566_7788) begin
            n_bad++; $display("FAIL lw_after_reset: got %h want 55667788", ld);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] ld, wd, word;
        word = $urandom;
        set_word(12, word);
        do_op(3'b000, 1'b0, 32'h30, 32'h0, 1'b1, ld, wd);
        n_vec++;
        if (ld !== word) begin
            n_bad++; $display("FAIL lw_held_start: got %h want %h", ld, word);
        end
        do_op(3'b011, 1'b0, 32'h30, 32'h0, 1'b0, ld, wd);
        n_vec++;
        if (ld !== word) begin
            n_bad++; $display("FAIL illegal_keeps_load: got %h want %h", ld, word);
        end
    endtask

    task automatic test_random;
        logic [31:0] ld, wd;
        for (int i = 0; i < 16; i++) set_word(i, $urandom);
        for (int n = 0; n < 60; n++) begin
            do_op(3'($urandom_range(0, 7)), 1'($urandom), 32'($urandom_range(0, 63)), $urandom,
                  1'($urandom), ld, wd);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb_ext();
        test_sh_rmw();
        test_misaligned();
        test_reset_during_sb();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
